axis_pkt_rr_arbiter: RTL and testbench
======================================

// Module: axis_pkt_rr_arbiter
// PURPOSE
//  Packet-granular round-robin arbiter sharing one AXI-Stream output among NUM_IN inputs.
//  Replaces the externally driven sel of the stream mux: the arbiter decides and locks the grant.
//  Once granted, an input owns the output until its tlast beat handshakes.
//  Sits between the per-source stream producers and the downstream stream consumer.
// PARAMETERS
//  NUM_IN     2    number of input streams (>=2)
//  DATA_W     8    tdata width in bits
//  MAX_BEATS  256  packet length limit in beats; overrun is flagged, not truncated
// PORTS
//  clk           in   1                 clock, all logic on rising edge
//  reset_n       in   1                 synchronous reset, active-low
//  s_tdata       in   NUM_IN*DATA_W     input data, input i at [i*DATA_W +: DATA_W]
//  s_tvalid      in   NUM_IN            per-input valid
//  s_tlast       in   NUM_IN            per-input last
//  s_tready      out  NUM_IN            per-input ready
//  m_tdata       out  DATA_W            output data
//  m_tvalid      out  1                 output valid
//  m_tlast       out  1                 output last
//  m_tready      in   1                 output ready
//  grant_idx     out  max(1,clog2(NUM_IN))  index of the current/last granted input
//  busy          out  1                 1 while in GRANT state
//  err_overlong  out  1                 1-cycle pulse on a packet exceeding MAX_BEATS
// BEHAVIOUR
//  Reset (reset_n=0 at edge): state=IDLE, rr_ptr=0, grant_idx=0, beat_cnt=0,
//   err_overlong=0. Combinational outputs then give m_tvalid=0, m_tlast=0, s_tready=0.
//   m_tdata is don't-care. Reset mid-packet abandons the packet; no tlast is emitted.
//  FSM, two states:
//   IDLE: m_tvalid=0, s_tready=all 0. If any s_tvalid, grant goes to the first asserted
//    input searching rr_ptr, rr_ptr+1, ... mod NUM_IN. At the edge, latch grant_idx and
//    go to GRANT. This gives 1 cycle of arbitration latency. With no request, stay in IDLE.
//   GRANT: combinational pass-through of the granted input, zero latency:
//    m_tdata/m_tvalid/m_tlast = input[grant_idx].
//    s_tready[grant_idx] = m_tready; all other s_tready = 0.
//    Beat = m_tvalid && m_tready. On a beat with m_tlast=1: rr_ptr <= grant_idx+1
//    (wraps to 0 after NUM_IN-1), beat_cnt <= 0, next state IDLE. This forces one bubble
//    cycle between packets.
//  Grant lock: the grant is never changed before the tlast beat. If the granted input
//   drops tvalid mid-packet, m_tvalid=0 and the grant is held. Other requesters wait.
//  Fairness: after input k finishes, k has lowest priority. Simultaneous requests are
//   served in rr order.
//  Overlong packet: beat_cnt (width clog2(MAX_BEATS+1)) counts beats in the packet and
//   saturates at MAX_BEATS. A non-last beat taken when beat_cnt==MAX_BEATS-1 pulses
//   err_overlong for 1 cycle (once per packet). Data keeps flowing and the grant is held.
//  busy = (state==GRANT). grant_idx holds its value in IDLE.
//  Backpressure: m_tready=0 stalls all inputs with no data loss and no duplication.
// TESTING
//  1 Reset: hold reset_n=0 for 3 cycles with all s_tvalid=1 -> m_tvalid=0, s_tready=0,
//    busy=0, grant_idx=0.
//  2 Both inputs request, 3-beat packets (0xA0..A2 on 0, 0xB0..B2 on 1), m_tready=1 ->
//    output A0 A1 A2(last), 1 bubble, B0 B1 B2(last). Input 0 first because rr_ptr=0.
//  3 Input 1 sends 2 packets back-to-back while input 0 requests after the first ->
//    order is pkt1a, pkt0, pkt1b (rr rotation honoured).
//  4 Granted input drops tvalid for 4 cycles mid-packet while input 1 is valid ->
//    m_tvalid=0, grant_idx unchanged, s_tready[1]=0 throughout.
//  5 Random m_tready toggling (50%) over 100 packets of random length 1..16 on 2 inputs ->
//    scoreboard shows no loss, duplication or interleave; tlast boundaries preserved.
//  6 MAX_BEATS=4, send a 6-beat packet -> err_overlong high exactly on beat 4,
//    all 6 beats delivered, then grant released on tlast.

Source files
------------

// File: rtl/axis_pkt_rr_arbiter_if.sv
// Stream bundle shared by the packet arbiter and its neighbours: NUM_IN slave
// inputs packed side by side plus the single merged master output.
`timescale 1ns/1ps
interface axis_pkt_rr_arbiter_if #(
    parameter int NUM_IN = 2,
    parameter int DATA_W = 8
);
    logic [NUM_IN*DATA_W-1:0] s_tdata;
    logic [NUM_IN-1:0]        s_tvalid;
    logic [NUM_IN-1:0]        s_tlast;
    logic [NUM_IN-1:0]        s_tready;
    logic [DATA_W-1:0]        m_tdata;
    logic                     m_tvalid;
    logic                     m_tlast;
    logic                     m_tready;

    // Arbiter side: consumes the inputs, drives the merged output.
    modport slave (
        input  s_tdata, s_tvalid, s_tlast, m_tready,
        output s_tready, m_tdata, m_tvalid, m_tlast
    );

    // Environment side: producers and the downstream consumer.
    modport master (
        output s_tdata, s_tvalid, s_tlast, m_tready,
        input  s_tready, m_tdata, m_tvalid, m_tlast
    );
endinterface

// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-granular round-robin arbiter: one input owns the output stream from
// grant until its tlast beat handshakes, then priority rotates past it.
`timescale 1ns/1ps
module axis_pkt_rr_arbiter #(
    parameter  int NUM_IN    = 2,
    parameter  int DATA_W    = 8,
    parameter  int MAX_BEATS = 256,
    localparam int GW        = (NUM_IN > 1) ? $clog2(NUM_IN) : 1,
    localparam int CW        = $clog2(MAX_BEATS + 1)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    axis_pkt_rr_arbiter_if.slave    bus,
    output logic [GW-1:0]           grant_idx,
    output logic                    busy,
    output logic                    err_overlong
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state, state_nxt;
    logic [GW-1:0]   rr_ptr, rr_ptr_nxt, grant_nxt;
    logic [CW-1:0]   beat_cnt, beat_cnt_nxt;
    logic            err_nxt;
    logic            sel_valid, sel_last;
    logic [DATA_W-1:0] sel_data;

    assign sel_valid = bus.s_tvalid[grant_idx];
    assign sel_last  = bus.s_tlast[grant_idx];
    assign sel_data  = bus.s_tdata[int'(grant_idx)*DATA_W +: DATA_W];
    assign busy      = (state == GRANT);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            grant_idx    <= '0;
            beat_cnt     <= '0;
            err_overlong <= 1'b0;
        end else begin
            state        <= state_nxt;
            rr_ptr       <= rr_ptr_nxt;
            grant_idx    <= grant_nxt;
            beat_cnt     <= beat_cnt_nxt;
            err_overlong <= err_nxt;
        end
    end

    always_comb begin
        int  idx;
        logic found;
        idx          = 0;
        found        = 1'b0;
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        grant_nxt    = grant_idx;
        beat_cnt_nxt = beat_cnt;
        err_nxt      = 1'b0;
        bus.m_tdata  = sel_data;
        bus.m_tvalid = 1'b0;
        bus.m_tlast  = 1'b0;
        bus.s_tready = '0;

        case (state)
            IDLE: begin
                // Search starts at rr_ptr so the last served input is considered last.
                for (int k = 0; k < NUM_IN; k++) begin
                    idx = (int'(rr_ptr) + k) % NUM_IN;
                    if (!found && bus.s_tvalid[idx]) begin
                        found     = 1'b1;
                        grant_nxt = GW'(idx);
                    end
                end
                if (found) state_nxt = GRANT;
            end
            GRANT: begin
                bus.m_tvalid            = sel_valid;
                bus.m_tlast             = sel_last;
                bus.s_tready[grant_idx] = bus.m_tready;
                if (sel_valid && bus.m_tready) begin
                    if (sel_last) begin
                        rr_ptr_nxt   = (grant_idx == GW'(NUM_IN - 1)) ? '0 : grant_idx + GW'(1);
                        beat_cnt_nxt = '0;
                        state_nxt    = IDLE;
                    end else begin
                        // Counter saturates, so the equality below fires once per packet.
                        if (beat_cnt == CW'(MAX_BEATS - 1)) err_nxt = 1'b1;
                        if (beat_cnt != CW'(MAX_BEATS)) beat_cnt_nxt = beat_cnt + CW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// Bench for the packet round-robin arbiter: packet-level reference model with
// per-input scoreboards, checked every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_axis_pkt_rr_arbiter;
    localparam int N  = 2;
    localparam int DW = 8;
    localparam int MB = 4;
    localparam int GW = 1;

    localparam logic [7:0] T2_D [6] = '{8'hA0, 8'hA1, 8'hA2, 8'hB0, 8'hB1, 8'hB2};
    localparam logic [7:0] T3_D [9] = '{8'h10, 8'h11, 8'h12, 8'hC0, 8'hC1, 8'hC2, 8'h18, 8'h19, 8'h1A};
    localparam int         T3_S [9] = '{1, 1, 1, 0, 0, 0, 1, 1, 1};

    typedef struct { logic [7:0] d; bit l; } beat_t;
    typedef struct { int src; logic [7:0] d; bit l; int cyc; } log_t;

    logic clk = 1'b0;
    logic reset_n;
    logic [GW-1:0] grant_idx;
    logic busy, err_overlong;

    axis_pkt_rr_arbiter_if #(.NUM_IN(N), .DATA_W(DW)) bus ();

    axis_pkt_rr_arbiter #(.NUM_IN(N), .DATA_W(DW), .MAX_BEATS(MB)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus),
        .grant_idx    (grant_idx),
        .busy         (busy),
        .err_overlong (err_overlong)
    );

    always #5 clk = ~clk;

    beat_t drv_q [N][$];
    beat_t exp_q [N][$];
    log_t  log_q [$];
    int    n_chk = 0, n_fail = 0;
    int    own = -1, ptr = 0, gidx = 0, pkt_beats = 0;
    bit    err_exp = 1'b0, chk_en = 1'b0;
    bit    all_valid = 1'b0, rdy_mode = 1'b0, gap_mode = 1'b0;
    bit    [N-1:0] acc = '0, tv = '0;
    int    hold [N];
    int    cyc = 0, err_cnt = 0, err_cyc = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: packet owner, rotating priority pointer, beats taken in packet.
    always @(negedge clk) begin
        bit ev;
        logic [N-1:0] er;
        int pick;
        beat_t b;
        cyc++;
        acc = bus.s_tvalid & bus.s_tready;
        if (chk_en) begin
            ev = (own >= 0) ? bus.s_tvalid[own] : 1'b0;
            er = '0;
            if (own >= 0) er[own] = bus.m_tready;
            chk("busy", busy, own >= 0);
            chk("grant_idx", grant_idx, gidx);
            chk("err_overlong", err_overlong, err_exp);
            chk("m_tvalid", bus.m_tvalid, ev);
            chk("s_tready", bus.s_tready, er);
            if (err_overlong) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (ev && bus.m_tready) begin
                if (exp_q[own].size() == 0) begin
                    chk("sb_extra_beat", exp_q[own].size(), 1);
                end else begin
                    b = exp_q[own].pop_front();
                    chk("sb_data", bus.m_tdata, b.d);
                    chk("sb_last", bus.m_tlast, b.l);
                end
                log_q.push_back('{own, bus.m_tdata, bus.m_tlast, cyc});
            end
        end
        if (!reset_n) begin
            own = -1; ptr = 0; gidx = 0; pkt_beats = 0; err_exp = 1'b0;
        end else begin
            err_exp = 1'b0;
            if (own < 0) begin
                pick = -1;
                for (int k = 0; k < N; k++)
                    if (pick < 0 && bus.s_tvalid[(ptr + k) % N]) pick = (ptr + k) % N;
                if (pick >= 0) begin
                    own  = pick;
                    gidx = pick;
                end
            end else if (bus.s_tvalid[own] && bus.m_tready) begin
                if (bus.s_tlast[own]) begin
                    ptr = (own + 1) % N;
                    own = -1;
                    pkt_beats = 0;
                end else begin
                    pkt_beats++;
                    if (pkt_beats == MB) err_exp = 1'b1;
                end
            end
        end
    end

    // Producers and consumer: present queued beats, hold valid until accepted.
    initial begin
        bus.s_tdata = '0; bus.s_tvalid = '0; bus.s_tlast = '0; bus.m_tready = 1'b0;
        for (int i = 0; i < N; i++) hold[i] = 0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
                if (all_valid) tv[i] = 1'b1;
                else if (hold[i] > 0) begin
                    hold[i]--;
                    tv[i] = 1'b0;
                end else if (tv[i] && !acc[i] && drv_q[i].size() > 0) tv[i] = 1'b1;
                else tv[i] = (drv_q[i].size() > 0) && (!gap_mode || $urandom_range(0, 3) != 0);
                bus.s_tdata[i*DW +: DW] = (drv_q[i].size() > 0) ? drv_q[i][0].d : 8'h00;
                bus.s_tlast[i]          = (drv_q[i].size() > 0) ? drv_q[i][0].l : 1'b0;
            end
            bus.s_tvalid = tv;
            bus.m_tready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic push_beat(input int i, input logic [7:0] d, input bit l);
        drv_q[i].push_back('{d, l});
        exp_q[i].push_back('{d, l});
    endtask

    function automatic bit all_done();
        for (int i = 0; i < N; i++)
            if (drv_q[i].size() > 0 || exp_q[i].size() > 0) return 1'b0;
        return own < 0;
    endfunction

    task automatic drain(input string nm, input int budget);
        bit ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            if (all_done()) begin
                ok = 1'b1;
                break;
            end
        end
        chk(nm, ok, 1);
        repeat (2) @(posedge clk);
    endtask

    task automatic wait_log(input string nm, input int n, input int budget);
        bit ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            if (log_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
        chk(nm, ok, 1);
    endtask

    initial begin
        int len;
        // Reset with every input requesting.
        reset_n = 1'b0;
        all_valid = 1'b1;
        repeat (3) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("t1_m_tvalid", bus.m_tvalid, 0);
        chk("t1_s_tready", bus.s_tready, 0);
        chk("t1_busy", busy, 0);
        chk("t1_grant_idx", grant_idx, 0);
        all_valid = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b1;

        // Simultaneous 3-beat packets: input 0 first, one bubble, then input 1.
        log_q.delete();
        for (int b = 0; b < 3; b++) push_beat(0, T2_D[b], b == 2);
        for (int b = 0; b < 3; b++) push_beat(1, T2_D[b+3], b == 2);
        drain("t2_drain", 200);
        chk("t2_count", log_q.size(), 6);
        for (int k = 0; k < log_q.size() && k < 6; k++) begin
            chk("t2_data", log_q[k].d, T2_D[k]);
            chk("t2_last", log_q[k].l, (k == 2 || k == 5));
        end
        if (log_q.size() >= 6) chk("t2_bubble", log_q[3].cyc - log_q[2].cyc, 2);

        // Input 1 back-to-back packets; input 0 joins during the first one.
        log_q.delete();
        for (int b = 0; b < 3; b++) push_beat(1, 8'h10 + 8'(b), b == 2);
        for (int b = 0; b < 3; b++) push_beat(1, 8'h18 + 8'(b), b == 2);
        wait_log("t3_first_beat", 1, 50);
        for (int b = 0; b < 3; b++) push_beat(0, 8'hC0 + 8'(b), b == 2);
        drain("t3_drain", 200);
        chk("t3_count", log_q.size(), 9);
        for (int k = 0; k < log_q.size() && k < 9; k++) begin
            chk("t3_data", log_q[k].d, T3_D[k]);
            chk("t3_src", log_q[k].src, T3_S[k]);
        end

        // Granted input stalls mid-packet while input 1 waits.
        log_q.delete();
        for (int b = 0; b < 4; b++) push_beat(0, 8'h40 + 8'(b), b == 3);
        for (int b = 0; b < 2; b++) push_beat(1, 8'h50 + 8'(b), b == 1);
        wait_log("t4_two_beats", 2, 50);
        hold[0] = 4;
        repeat (4) begin
            @(negedge clk);
            chk("t4_m_tvalid", bus.m_tvalid, 0);
            chk("t4_grant_idx", grant_idx, 0);
            chk("t4_s_tready1", bus.s_tready[1], 0);
            chk("t4_busy", busy, 1);
        end
        drain("t4_drain", 200);
        chk("t4_count", log_q.size(), 6);
        if (log_q.size() >= 6) begin
            chk("t4_pkt0_end", log_q[3].d, 8'h43);
            chk("t4_pkt1_start", log_q[4].d, 8'h50);
        end

        // 6-beat packet against a 4-beat limit.
        log_q.delete();
        err_cnt = 0;
        for (int b = 0; b < 6; b++) push_beat(0, 8'hD0 + 8'(b), b == 5);
        drain("t6_drain", 200);
        chk("t6_count", log_q.size(), 6);
        chk("t6_err_pulses", err_cnt, 1);
        if (log_q.size() >= 6) begin
            chk("t6_err_on_beat4", err_cyc - log_q[3].cyc, 1);
            chk("t6_last", log_q[5].l, 1);
        end
        @(negedge clk);
        chk("t6_released", busy, 0);

        // Random traffic with consumer backpressure and producer gaps.
        log_q.delete();
        rdy_mode = 1'b1;
        gap_mode = 1'b1;
        for (int p = 0; p < 50; p++)
            for (int i = 0; i < N; i++) begin
                len = $urandom_range(1, 16);
                for (int b = 0; b < len; b++) push_beat(i, 8'($urandom), b == len - 1);
            end
        drain("t5_drain", 40000);
        len = 0;
        for (int k = 0; k < log_q.size(); k++) if (log_q[k].l) len++;
        chk("t5_packets", len, 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end
endmodule
